exp2_iter: RTL

//  Iterative fixed-point antilog: computes 2^x for signed Q(M).(N) x. Inverse of the LOG2 unit.

---
 rtl/sqrtlog_pkg.sv | 46 ++++
 rtl/shift_add_mul.sv | 67 ++++++
 rtl/exp2_iter.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/sqrtlog_pkg.sv
// -----------------------------------------------------------------------------
// sqrtlog_pkg
//   Shared definitions for the SQRTLOG arithmetic units.
//   - EXP2_M / EXP2_N / EXP2_G : default integer, fraction and guard widths
//     of the exp2_iter antilog unit.
//   - exp2_state_t            : exp2_iter FSM state encoding.
//   - exp2_const(i)           : constant ROM C[i] = round(2^(2^-i) * 2^(N+G)).
// -----------------------------------------------------------------------------
package sqrtlog_pkg;

    localparam int EXP2_M = 10;
    localparam int EXP2_N = 10;
    localparam int EXP2_G = 4;

    typedef enum logic [2:0] {
        INIT  = 3'd0,
        WAIT  = 3'd1,
        SPLIT = 3'd2,
        STEP  = 3'd3,
        MUL   = 3'd4,
        ROUND = 3'd5,
        SHIFT = 3'd6,
        SEND  = 3'd7
    } exp2_state_t;

    // C[i] scaled by 2^(N+G) with N+G = 14. Index 0 and anything past N
    // return 1.0 so a stray index cannot corrupt the accumulator.
    function automatic logic [31:0] exp2_const(input int i);
        logic [31:0] c;
        case (i)
            32'sd1:  c = 32'd23170;
            32'sd2:  c = 32'd19484;
            32'sd3:  c = 32'd17867;
            32'sd4:  c = 32'd17109;
            32'sd5:  c = 32'd16743;
            32'sd6:  c = 32'd16562;
            32'sd7:  c = 32'd16473;
            32'sd8:  c = 32'd16428;
            32'sd9:  c = 32'd16406;
            32'sd10: c = 32'd16395;
            default: c = 32'd16384;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/shift_add_mul.sv
// -----------------------------------------------------------------------------
// shift_add_mul
//   Sequential unsigned shift-and-add multiplier, one multiplier bit per
//   cycle. start loads the operands; done pulses for one cycle W cycles
//   later (W+1 cycles including the start cycle), with p valid from then on
//   until the next start.
//   Ports: clock, reset (sync, active-high), start, a[W-1:0], b[W-1:0],
//          done, p[2W-1:0].
// -----------------------------------------------------------------------------
module shift_add_mul #(
    parameter int W = 15
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           start,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           done,
    output logic [2*W-1:0] p
);

    localparam int CW = $clog2(W + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    logic [2*W-1:0] mcand_r;
    logic [2*W-1:0] p_r;
    logic [W-1:0]   mplier_r;
    logic [CW-1:0]  cnt_r;
    logic           busy_r;
    logic           done_r;

    // Operand load, then one conditional add per multiplier bit, LSB first.
    always_ff @(posedge clock) begin
        if (reset) begin
            mcand_r  <= {(2*W){1'b0}};
            p_r      <= {(2*W){1'b0}};
            mplier_r <= {W{1'b0}};
            cnt_r    <= {CW{1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else if (start) begin
            mcand_r  <= {{W{1'b0}}, a};
            p_r      <= {(2*W){1'b0}};
            mplier_r <= b;
            cnt_r    <= {CW{1'b0}};
            busy_r   <= 1'b1;
            done_r   <= 1'b0;
        end else if (busy_r) begin
            if (mplier_r[0]) begin
                p_r <= p_r + mcand_r;
            end
            mcand_r  <= mcand_r << 1;
            mplier_r <= mplier_r >> 1;
            cnt_r    <= cnt_r + CW'(1);
            if (cnt_r == CNT_LAST) begin
                busy_r <= 1'b0;
                done_r <= 1'b1;
            end
        end else begin
            done_r <= 1'b0;
        end
    end

    assign done = done_r;
    assign p    = p_r;

endmodule

// File: rtl/exp2_iter.sv
// -----------------------------------------------------------------------------
// exp2_iter
//   Iterative fixed-point antilog: expNumber = 2^number.
//   number is split into a signed integer part ip and an N-bit fraction fr.
//   2^fr is built as a product of ROM constants 2^(2^-i), one multiply per
//   set fraction bit, then scaled by 2^ip through a barrel shifter with
//   saturation on overflow.
//   Ports:
//     clock, reset          clock; synchronous active-high reset
//     number[M+N:0]         signed input, N fraction bits
//     iValid / iReady       input handshake (iReady high only when idle)
//     expNumber[M+N-1:0]    unsigned result, N fraction bits
//     ovf                   result saturated to all ones
//     oValid / oReady       output handshake; result held while oValid
// -----------------------------------------------------------------------------
module exp2_iter
    import sqrtlog_pkg::*;
#(
    parameter int M = EXP2_M,
    parameter int N = EXP2_N,
    parameter int G = EXP2_G
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [M+N:0]     number,
    input  logic             iValid,
    output logic             iReady,
    output logic [M+N-1:0]   expNumber,
    output logic             ovf,
    output logic             oValid,
    input  logic             oReady
);

    localparam int AW  = N + G + 2;      // accumulator
    localparam int W   = N + G + 1;      // multiplier operand width
    localparam int IPW = M + 1;          // signed integer part
    localparam int MW  = N + 2;          // rounded mantissa
    localparam int OW  = M + N;          // result
    localparam int PW  = AW + M;         // left-shifted accumulator
    localparam int IW  = $clog2(N + 2);  // fraction bit index 1..N+1

    localparam logic [AW-1:0]        ACC_ONE  = {{(AW-1){1'b0}}, 1'b1} << (N + G);
    localparam logic [AW-1:0]        ACC_HALF = {{(AW-1){1'b0}}, 1'b1} << (G - 1);
    localparam logic [PW-1:0]        PW_HALF  = {{(PW-1){1'b0}}, 1'b1} << (G - 1);
    localparam logic [IW-1:0]        I_LAST   = IW'(N);
    localparam logic [IW-1:0]        I_FIRST  = IW'(1);
    localparam logic signed [IPW-1:0] IP_MAX  = IPW'(M - 1);
    localparam logic [IPW:0]         SH_LIMIT = (IPW + 1)'(MW);

    exp2_state_t            state_r;
    exp2_state_t            state_next_s;

    logic [M+N:0]           num_r;
    logic signed [IPW-1:0]  ip_r;
    logic [N-1:0]           fr_r;
    logic [IW-1:0]          i_r;
    logic [AW-1:0]          acc_r;
    logic [MW-1:0]          mant_r;
    logic [OW-1:0]          exp_r;
    logic                   ovf_r;
    logic                   i_ready_r;
    logic                   o_valid_r;

    logic                   mul_start_s;
    logic                   mul_done_s;
    logic [2*W-1:0]         mul_p_s;
    logic [W-1:0]           mul_b_s;

    logic [IPW:0]           neg_sh_s;
    logic [PW-1:0]          pos_wide_s;
    logic [OW-1:0]          res_s;
    logic                   res_ovf_s;

    assign mul_b_s = W'(exp2_const(int'(i_r)));

    // The accumulator stays below 2.0, so its top bit is never needed by
    // the multiplier.
    shift_add_mul #(
        .W (W)
    ) u_mul (
        .clock (clock),
        .reset (reset),
        .start (mul_start_s),
        .a     (acc_r[W-1:0]),
        .b     (mul_b_s),
        .done  (mul_done_s),
        .p     (mul_p_s)
    );

    // Next-state logic and multiplier start strobe.
    always_comb begin
        state_next_s = state_r;
        mul_start_s  = 1'b0;
        case (state_r)
            INIT:  state_next_s = WAIT;
            WAIT: begin
                if (iValid && i_ready_r) begin
                    state_next_s = SPLIT;
                end else begin
                    state_next_s = WAIT;
                end
            end
            SPLIT: state_next_s = STEP;
            STEP: begin
                if (i_r > I_LAST) begin
                    state_next_s = ROUND;
                end else if (fr_r[N-1]) begin
                    state_next_s = MUL;
                    mul_start_s  = 1'b1;
                end else begin
                    state_next_s = STEP;
                end
            end
            MUL: begin
                if (mul_done_s) begin
                    state_next_s = STEP;
                end else begin
                    state_next_s = MUL;
                end
            end
            ROUND: state_next_s = SHIFT;
            SHIFT: state_next_s = SEND;
            SEND: begin
                if (oReady) begin
                    state_next_s = INIT;
                end else begin
                    state_next_s = SEND;
                end
            end
            default: state_next_s = INIT;
        endcase
    end

    // Barrel shift and saturation. A positive exponent rounds after the
    // shift so the guard bits are not thrown away before being magnified;
    // a negative exponent truncates the rounded mantissa.
    always_comb begin
        neg_sh_s   = {(IPW+1){1'b0}} - {ip_r[IPW-1], ip_r};
        pos_wide_s = ((PW'(acc_r) << $unsigned(ip_r)) + PW_HALF) >> G;
        res_s      = {OW{1'b0}};
        res_ovf_s  = 1'b0;
        if (ip_r[IPW-1]) begin
            if (neg_sh_s >= SH_LIMIT) begin
                res_s = {OW{1'b0}};
            end else begin
                res_s = OW'(mant_r >> neg_sh_s);
            end
        end else if ((ip_r > IP_MAX) || (|pos_wide_s[PW-1:OW])) begin
            res_s     = {OW{1'b1}};
            res_ovf_s = 1'b1;
        end else begin
            res_s = pos_wide_s[OW-1:0];
        end
    end

    // State register and datapath registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r   <= INIT;
            num_r     <= {(M+N+1){1'b0}};
            ip_r      <= {IPW{1'b0}};
            fr_r      <= {N{1'b0}};
            i_r       <= {IW{1'b0}};
            acc_r     <= {AW{1'b0}};
            mant_r    <= {MW{1'b0}};
            exp_r     <= {OW{1'b0}};
            ovf_r     <= 1'b0;
            i_ready_r <= 1'b0;
            o_valid_r <= 1'b0;
        end else begin
            state_r <= state_next_s;
            case (state_r)
                INIT: begin
                    acc_r     <= ACC_ONE;
                    i_r       <= I_FIRST;
                    i_ready_r <= 1'b1;
                    o_valid_r <= 1'b0;
                end
                WAIT: begin
                    if (iValid && i_ready_r) begin
                        num_r     <= number;
                        i_ready_r <= 1'b0;
                    end
                end
                SPLIT: begin
                    ip_r <= num_r[M+N:N];
                    fr_r <= num_r[N-1:0];
                end
                STEP: begin
                    // fr_r shifts left so the bit for step i is always at the top.
                    if ((i_r <= I_LAST) && !fr_r[N-1]) begin
                        i_r  <= i_r + IW'(1);
                        fr_r <= fr_r << 1;
                    end
                end
                MUL: begin
                    if (mul_done_s) begin
                        acc_r <= AW'(mul_p_s >> (N + G));
                        i_r   <= i_r + IW'(1);
                        fr_r  <= fr_r << 1;
                    end
                end
                ROUND: begin
                    mant_r <= MW'((acc_r + ACC_HALF) >> G);
                end
                SHIFT: begin
                    exp_r     <= res_s;
                    ovf_r     <= res_ovf_s;
                    o_valid_r <= 1'b1;
                end
                SEND: begin
                    if (oReady) begin
                        o_valid_r <= 1'b0;
                    end
                end
                default: begin
                    o_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign iReady    = i_ready_r;
    assign oValid    = o_valid_r;
    assign expNumber = exp_r;
    assign ovf       = ovf_r;

endmodule
